// File: rtl/mem_stage_ctrl.sv
// MEM1 stage controller: sequences one data-memory access per instruction into MEM2.
// Optional build macro MEM_STAGE_CTRL_PERF_EN adds the perf_stall_cycles_o stall counter.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        mem1_valid_i,
  input  logic        mem1_is_mem_i,
  input  logic        mem1_is_store_i,
  input  logic        flush_i,
  input  logic        mem2_ready_i,
  input  logic        dmem_req_ready_i,
  input  logic        dmem_rsp_valid_i,
  output logic        dmem_req_valid_o,
  output logic        pipe_we_o,
  output logic        pipe_bubble_o,
  output logic        stall_o,
  output logic        fault_o,
`ifdef MEM_STAGE_CTRL_PERF_EN
  output logic [31:0] perf_stall_cycles_o,
`endif
  output logic        busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_e      state_reg;
  state_e      state_next;
  logic [15:0] wait_cnt_reg;
  logic [15:0] wait_cnt_next;
  logic [15:0] wait_cnt_inc;
  logic        fault_reg;
  logic        fault_next;
  logic        issue_mem;

  assign issue_mem    = mem1_valid_i && !flush_i && mem1_is_mem_i;
  assign wait_cnt_inc = wait_cnt_reg + 16'd1;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
      fault_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      fault_reg    <= fault_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    fault_next    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (issue_mem) begin
          wait_cnt_next = '0;
          if (dmem_req_ready_i) begin
            state_next = mem1_is_store_i ? ST_DONE : ST_WAIT;
          end else begin
            state_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (dmem_req_ready_i) begin
          wait_cnt_next = '0;
          // A load accepted in the flush cycle still returns data that must be swallowed.
          if (flush_i) begin
            state_next = mem1_is_store_i ? ST_IDLE : ST_DRAIN;
          end else begin
            state_next = mem1_is_store_i ? ST_DONE : ST_WAIT;
          end
        end else if (flush_i) begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        wait_cnt_next = wait_cnt_inc;
        if (flush_i && dmem_rsp_valid_i) begin
          state_next = ST_IDLE;
        end else if (flush_i) begin
          state_next = ST_DRAIN;
        end else if (dmem_rsp_valid_i) begin
          state_next = ST_DONE;
        end else if (wait_cnt_inc == TIMEOUT_LIMIT) begin
          state_next = ST_DRAIN;
          fault_next = 1'b1;
        end
      end
      ST_DONE: begin
        if (flush_i || mem2_ready_i) begin
          state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (dmem_rsp_valid_i) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    dmem_req_valid_o = 1'b0;
    stall_o          = 1'b0;
    pipe_bubble_o    = 1'b1;
    if (!rst) begin
      case (state_reg)
        ST_IDLE: begin
          if (mem1_valid_i && !flush_i) begin
            if (mem1_is_mem_i) begin
              dmem_req_valid_o = 1'b1;
              stall_o          = 1'b1;
            end else if (mem2_ready_i) begin
              pipe_bubble_o = 1'b0;
            end else begin
              stall_o = 1'b1;
            end
          end
        end
        ST_REQ: begin
          dmem_req_valid_o = 1'b1;
          stall_o          = 1'b1;
        end
        ST_WAIT: begin
          stall_o = 1'b1;
        end
        ST_DONE: begin
          if (!flush_i) begin
            if (mem2_ready_i) begin
              pipe_bubble_o = 1'b0;
            end else begin
              stall_o = 1'b1;
            end
          end
        end
        default: begin
          stall_o = 1'b0;
        end
      endcase
    end
  end

  assign pipe_we_o = mem2_ready_i;
  assign fault_o   = fault_reg && !rst;
  assign busy_o    = (state_reg != ST_IDLE);

`ifdef MEM_STAGE_CTRL_PERF_EN
  logic [31:0] perf_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      perf_cnt_reg <= '0;
    end else if (stall_o) begin
      perf_cnt_reg <= perf_cnt_reg + 32'd1;
    end
  end

  assign perf_stall_cycles_o = perf_cnt_reg;
`endif

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, max WAIT cycles before fault (1..65535).
REQ-002 clk_i  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 mem1_valid_i  in  1  MEM1 holds a valid instruction.
REQ-005 mem1_is_mem_i  in  1  MEM1 instruction is a load or store.
REQ-006 mem1_is_store_i  in  1  MEM1 memory instruction is a store (ignored unless mem1_is_mem_i).
REQ-007 flush_i  in  1  kill MEM1 instruction (redirect/trap).
REQ-008 mem2_ready_i  in  1  MEM2 can accept a new MEM1->MEM2 register value.
REQ-009 dmem_req_ready_i  in  1  data memory accepts request.
REQ-010 dmem_rsp_valid_i  in  1  data memory load response valid.
REQ-011 dmem_req_valid_o  out  1  data memory request valid.
REQ-012 pipe_we_o  out  1  load enable of MEM1->MEM2 pipeline register.
REQ-013 pipe_bubble_o  out  1  when loading, load all-zero (bubble) instead of MEM1 data.
REQ-014 stall_o  out  1  hold MEM1 and all upstream stages.
REQ-015 fault_o  out  1  one-cycle pulse: memory response timeout.
REQ-016 busy_o  out  1  FSM not in IDLE.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, DONE, DRAIN; encoding free.
REQ-018 pipe_we_o SHALL equal mem2_ready_i every cycle; pipe_bubble_o=1 in every cycle not delivering the MEM1 instruction.
REQ-019 IDLE, mem1_valid_i=0 or flush_i=1: bubble, stall_o=0, stay IDLE.
REQ-020 IDLE, valid non-memory: deliver (bubble=0) if mem2_ready_i; else stall_o=1.
REQ-021 IDLE, valid memory op: dmem_req_valid_o=1 combinationally, stall_o=1; accepted -> store: DONE, load: WAIT; not accepted -> REQ.
REQ-022 REQ: dmem_req_valid_o=1 held until dmem_req_ready_i; same next-state rule as REQ-021; flush_i with no accept -> IDLE, request dropped.
REQ-023 WAIT: stall_o=1; dmem_rsp_valid_i -> DONE; timeout counter increments per WAIT cycle, clears on entry.
REQ-024 Counter reaching TIMEOUT_CYCLES with no response: fault_o=1 for one cycle, -> DRAIN.
REQ-025 DONE: stall_o=1 unless mem2_ready_i; mem2_ready_i=1 -> deliver (bubble=0), stall_o=0, -> IDLE.
REQ-026 flush_i in WAIT -> DRAIN; in DONE -> IDLE with bubble, no delivery.
REQ-027 DRAIN: stall_o=0, bubble; dmem_rsp_valid_i discarded -> IDLE.
REQ-028 Response arriving same cycle as flush_i in WAIT: discarded, -> IDLE.
REQ-029 At most one outstanding memory request; dmem_req_valid_o=0 in WAIT, DONE, DRAIN.
REQ-030 busy_o = (state != IDLE), registered-state based.

Reset
REQ-031 rst: state IDLE, counter 0, fault_o 0, perf counter 0; dmem_req_valid_o and stall_o 0 during rst.
REQ-032 rst mid-WAIT abandons request; late response in IDLE ignored.
REQ-033 rst overrides flush_i and all inputs.

Configuration
REQ-034 Macro MEM_STAGE_CTRL_PERF_EN defined: 32-bit output perf_stall_cycles_o counts stall_o=1 cycles, wraps at 2^32.
REQ-035 Macro undefined: port absent, no counter logic; other behaviour identical.

Verification
REQ-036 Non-memory op, mem2_ready_i=1 -> pipe_we_o=1, pipe_bubble_o=0, stall_o=0 same cycle.
REQ-037 Load, req_ready 2 cycles late, rsp 3 cycles after accept -> stall_o high 6 cycles, delivery in 7th.
REQ-038 Store accepted immediately, mem2_ready_i=0 two cycles -> DONE held, delivery when ready=1.
REQ-039 Load, no response, TIMEOUT_CYCLES=4 -> fault_o pulse after 4 WAIT cycles, DRAIN, later rsp discarded.
REQ-040 flush_i in WAIT, rsp next cycle -> no delivery, IDLE after rsp, stall_o=0 from flush cycle+1.
REQ-041 rst in WAIT; response next cycle -> ignored; PERF_EN build: perf_stall_cycles_o=0 after reset.
